csr_access_unit: RTL and testbench

- Requester side of the CSR data store: accepts CSR instructions (CSRRW/CSRRS/CSRRC and immediate forms) from issue.
- Drives the store's read port, computes the new CSR value, drives the store's write port, and returns the old value to writeback.
- Two-stage pipeline: R (read) then X (modify/write/respond), with valid/ready handshakes on both ends.
- Detects read-after-write hazards between the stages.

---
 rtl/csr_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_csr_access_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// CSR requester: two-stage read/modify-write pipeline (R: store read, X: write + response).
// Optional CSR_BYPASS_EN forwards X's pending value to R on same-address RAW instead of stalling.
module csr_access_unit #(
  parameter int NUM_THREADS   = 4,
  parameter int NW_BITS       = 2,
  parameter int CSR_ADDR_BITS = 12,
  parameter int CSR_WIDTH     = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [NW_BITS-1:0]          req_wid,
  input  logic [4:0]                  req_rd,
  input  logic [1:0]                  req_op,
  input  logic [CSR_ADDR_BITS-1:0]    req_addr,
  input  logic [31:0]                 req_src,
  input  logic                        req_src_zero,
  output logic                        read_enable,
  output logic [CSR_ADDR_BITS-1:0]    read_addr,
  output logic [NW_BITS-1:0]          read_wid,
  input  logic [31:0]                 read_data,
  output logic                        write_enable,
  output logic [CSR_ADDR_BITS-1:0]    write_addr,
  output logic [NW_BITS-1:0]          write_wid,
  output logic [CSR_WIDTH-1:0]        write_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [NW_BITS-1:0]          rsp_wid,
  output logic [4:0]                  rsp_rd,
  output logic [NUM_THREADS*32-1:0]   rsp_data,
  output logic                        busy
);

  localparam logic [CSR_ADDR_BITS-1:0] CSR_FFLAGS = CSR_ADDR_BITS'(12'h001);
  localparam logic [CSR_ADDR_BITS-1:0] CSR_FRM    = CSR_ADDR_BITS'(12'h002);
  localparam logic [CSR_ADDR_BITS-1:0] CSR_FCSR   = CSR_ADDR_BITS'(12'h003);

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  function automatic logic in_fp_group(input logic [CSR_ADDR_BITS-1:0] a);
    return (a == CSR_FFLAGS) || (a == CSR_FRM) || (a == CSR_FCSR);
  endfunction

  function automatic logic addr_alias(input logic [CSR_ADDR_BITS-1:0] a,
                                      input logic [CSR_ADDR_BITS-1:0] b);
    return (a == b) || (in_fp_group(a) && in_fp_group(b));
  endfunction

  // R stage
  logic                     r_r_valid;
  logic [NW_BITS-1:0]       r_r_wid;
  logic [4:0]               r_r_rd;
  logic [1:0]               r_r_op;
  logic [CSR_ADDR_BITS-1:0] r_r_addr;
  logic [31:0]              r_r_src;
  logic                     r_r_src_zero;

  // X stage
  logic                     r_x_valid;
  logic [NW_BITS-1:0]       r_x_wid;
  logic [4:0]               r_x_rd;
  logic [CSR_ADDR_BITS-1:0] r_x_addr;
  logic [31:0]              r_x_old;
  logic [CSR_WIDTH-1:0]     r_x_new;
  logic                     r_x_do_wr;

  logic        w_x_fire;
  logic        w_same_wr;
  logic        w_hazard;
  logic        w_stall;
  logic        w_r_adv;
  logic        w_accept;
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic        w_do_wr;
  logic        w_unused_new_hi;

  assign w_x_fire  = r_x_valid & rsp_ready;
  assign w_same_wr = r_x_valid & r_x_do_wr & (r_x_wid == r_r_wid);
  assign w_hazard  = w_same_wr & addr_alias(r_x_addr, r_r_addr);

`ifdef CSR_BYPASS_EN
  logic w_hazard_eq;
  assign w_hazard_eq = w_same_wr & (r_x_addr == r_r_addr);
  // Exact-address RAW resolves through forwarding once X retires this cycle;
  // cross-alias FP CSRs still wait for the store to commit.
  assign w_stall = w_hazard & ~(w_hazard_eq & w_x_fire);
  assign w_old   = w_hazard_eq ? {{(32-CSR_WIDTH){1'b0}}, r_x_new} : read_data;
`else
  assign w_stall = w_hazard;
  assign w_old   = read_data;
`endif

  assign w_r_adv  = r_r_valid & ~w_stall & (~r_x_valid | w_x_fire);
  assign w_accept = req_valid & req_ready;

  // New CSR value and write decision for the op sitting in R.
  always_comb begin
    w_new   = w_old;
    w_do_wr = 1'b0;
    case (r_r_op)
      OP_RW: begin
        w_new   = r_r_src;
        w_do_wr = 1'b1;
      end
      OP_RS: begin
        w_new   = w_old | r_r_src;
        w_do_wr = ~r_r_src_zero;
      end
      OP_RC: begin
        w_new   = w_old & ~r_r_src;
        w_do_wr = ~r_r_src_zero;
      end
      default: begin
        w_new   = w_old;
        w_do_wr = 1'b0;
      end
    endcase
  end

  assign w_unused_new_hi = ^w_new[31:CSR_WIDTH];

  // Stage occupancy; in-flight ops are dropped on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_r_valid <= 1'b0;
      r_x_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_r_valid <= 1'b1;
      end else if (w_r_adv) begin
        r_r_valid <= 1'b0;
      end
      if (w_r_adv) begin
        r_x_valid <= 1'b1;
      end else if (w_x_fire) begin
        r_x_valid <= 1'b0;
      end
    end
  end

  // Stage payload registers (no reset needed, qualified by the valids).
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_r_wid      <= req_wid;
      r_r_rd       <= req_rd;
      r_r_op       <= req_op;
      r_r_addr     <= req_addr;
      r_r_src      <= req_src;
      r_r_src_zero <= req_src_zero;
    end
    if (w_r_adv) begin
      r_x_wid   <= r_r_wid;
      r_x_rd    <= r_r_rd;
      r_x_addr  <= r_r_addr;
      r_x_old   <= w_old;
      r_x_new   <= w_new[CSR_WIDTH-1:0];
      r_x_do_wr <= w_do_wr;
    end
  end

  assign req_ready    = ~r_r_valid | w_r_adv;
  assign read_enable  = r_r_valid;
  assign read_addr    = r_r_addr;
  assign read_wid     = r_r_wid;

  // The store write is tied to the response handshake so it commits exactly once.
  assign write_enable = w_x_fire & r_x_do_wr;
  assign write_addr   = r_x_addr;
  assign write_wid    = r_x_wid;
  assign write_data   = r_x_new;

  assign rsp_valid    = r_x_valid;
  assign rsp_wid      = r_x_wid;
  assign rsp_rd       = r_x_rd;
  assign rsp_data     = {NUM_THREADS{r_x_old}};
  assign busy         = r_r_valid | r_x_valid;

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: program-order CSR model + scoreboard, directed and random traffic.
module tb_csr_access_unit;
  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_src_zero;
  logic [1:0]    req_wid, req_op;
  logic [4:0]    req_rd;
  logic [11:0]   req_addr;
  logic [31:0]   req_src;
  logic          read_enable;
  logic [11:0]   read_addr;
  logic [1:0]    read_wid;
  logic [31:0]   read_data;
  logic          write_enable;
  logic [11:0]   write_addr;
  logic [1:0]    write_wid;
  logic [11:0]   write_data;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_wid;
  logic [4:0]    rsp_rd;
  logic [NT*32-1:0] rsp_data;
  logic          busy;

  always #5 clk = ~clk;

  csr_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid), .req_rd(req_rd),
    .req_op(req_op), .req_addr(req_addr), .req_src(req_src), .req_src_zero(req_src_zero),
    .read_enable(read_enable), .read_addr(read_addr), .read_wid(read_wid), .read_data(read_data),
    .write_enable(write_enable), .write_addr(write_addr), .write_wid(write_wid), .write_data(write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wid(rsp_wid), .rsp_rd(rsp_rd),
    .rsp_data(rsp_data), .busy(busy)
  );

`ifdef CSR_BYPASS_EN
  localparam int RAW_GAP = 1;
`else
  localparam int RAW_GAP = 2;
`endif

  typedef struct {
    logic [1:0]  wid;
    logic [4:0]  rd;
    logic [31:0] old;
    logic        we;
    logic [11:0] addr;
    logic [11:0] wdata;
  } exp_t;

  typedef struct {
    time         t;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic [11:0] wdata;
  } log_t;

  logic [11:0] mem     [4][4096];
  logic [11:0] spec_m  [4][4096];
  logic [11:0] commit_m[4][4096];
  exp_t        exp_q[$];
  log_t        log_q[$];
  int          total = 0;
  int          bad   = 0;

  assign read_data = {20'd0, mem[read_wid][read_addr]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic store_proc();
    for (int w = 0; w < 4; w++)
      for (int a = 0; a < 4096; a++)
        mem[w][a] = 12'd0;
    forever begin
      @(posedge clk);
      if (write_enable) mem[write_wid][write_addr] <= write_data;
    end
  endtask

  task automatic monitor();
    exp_t e;
    log_t l;
    for (int w = 0; w < 4; w++)
      for (int a = 0; a < 4096; a++)
        commit_m[w][a] = 12'd0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (rsp_valid && exp_q.size() == 0) begin
          chk("spurious_rsp", 32'(rsp_valid), 32'd0);
        end else if (rsp_valid) begin
          e = exp_q[0];
          chk("rsp_wid", 32'(rsp_wid), 32'(e.wid));
          chk("rsp_rd", 32'(rsp_rd), 32'(e.rd));
          for (int i = 0; i < NT; i++) chk("rsp_data", rsp_data[i*32 +: 32], e.old);
          if (rsp_ready) begin
            chk("wr_en", 32'(write_enable), 32'(e.we));
            if (e.we) begin
              chk("wr_addr", 32'(write_addr), 32'(e.addr));
              chk("wr_wid", 32'(write_wid), 32'(e.wid));
              chk("wr_data", 32'(write_data), 32'(e.wdata));
              commit_m[e.wid][e.addr] = e.wdata;
            end
            l.t = $time; l.rd = e.rd; l.data = e.old; l.we = write_enable; l.wdata = write_data;
            log_q.push_back(l);
            void'(exp_q.pop_front());
          end else begin
            chk("wr_en_stalled", 32'(write_enable), 32'd0);
          end
        end else begin
          chk("wr_en_idle", 32'(write_enable), 32'd0);
        end
      end
    end
  endtask

  // Caller sits on a negedge; returns on the negedge after the request is accepted.
  task automatic send(input logic [1:0] w, input logic [4:0] rd, input logic [1:0] op,
                      input logic [11:0] a, input logic [31:0] src, input logic sz, input bit rnd);
    exp_t e;
    logic [31:0] old, nv;
    int n;
    req_valid = 1'b1; req_wid = w; req_rd = rd; req_op = op;
    req_addr = a; req_src = src; req_src_zero = sz;
    if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
    #1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      n++;
    end
    if (!req_ready) begin
      chk("req_timeout", 32'd0, 32'd1);
    end else begin
      old = {20'd0, spec_m[w][a]};
      case (op)
        2'b01:   nv = src;
        2'b10:   nv = old | src;
        2'b11:   nv = old & ~src;
        default: nv = old;
      endcase
      e.wid = w; e.rd = rd; e.old = old; e.addr = a; e.wdata = nv[11:0];
      e.we = (op == 2'b01) || (op[1] && !sz);
      if (e.we) spec_m[w][a] = nv[11:0];
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] addrs [6];
    logic [31:0] src;
    addrs[0] = 12'h001; addrs[1] = 12'h002; addrs[2] = 12'h003;
    addrs[3] = 12'h300; addrs[4] = 12'h305; addrs[5] = 12'h340;
    for (int w = 0; w < 4; w++)
      for (int a = 0; a < 4096; a++)
        spec_m[w][a] = 12'd0;
    reset = 1'b1; req_valid = 1'b0; req_wid = 2'd0; req_rd = 5'd0; req_op = 2'd0;
    req_addr = 12'd0; req_src = 32'd0; req_src_zero = 1'b0; rsp_ready = 1'b1;
    fork
      store_proc();
      monitor();
    join_none

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_read_en", 32'(read_enable), 32'd0);
    chk("rst_write_en", 32'(write_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);

    // RW then read-only to 0x300, same warp: RAW spacing
    log_q.delete();
    send(2'd0, 5'd1, 2'b01, 12'h300, 32'h0000_000A, 1'b0, 1'b0);
    send(2'd0, 5'd2, 2'b00, 12'h300, 32'd0, 1'b1, 1'b0);
    drain();
    if (log_q.size() == 2) begin
      chk("raw_rsp1", log_q[0].data, 32'h0);
      chk("raw_wdata1", 32'(log_q[0].wdata), 32'h00A);
      chk("raw_rsp2", log_q[1].data, 32'h00A);
      chk("raw_we2", 32'(log_q[1].we), 32'd0);
      chk("raw_gap", 32'((log_q[1].t - log_q[0].t) / 10), 32'(RAW_GAP));
    end else chk("raw_count", 32'(log_q.size()), 32'd2);

    // RS / RC / RS-with-src_zero on 0x340
    log_q.delete();
    send(2'd0, 5'd3, 2'b01, 12'h340, 32'h3, 1'b0, 1'b0);
    send(2'd0, 5'd4, 2'b10, 12'h340, 32'h5, 1'b0, 1'b0);
    send(2'd0, 5'd5, 2'b11, 12'h340, 32'h1, 1'b0, 1'b0);
    send(2'd0, 5'd6, 2'b10, 12'h340, 32'h0, 1'b1, 1'b0);
    drain();
    if (log_q.size() == 4) begin
      chk("rs_rsp", log_q[1].data, 32'h3);
      chk("rs_wdata", 32'(log_q[1].wdata), 32'h7);
      chk("rc_rsp", log_q[2].data, 32'h7);
      chk("rc_wdata", 32'(log_q[2].wdata), 32'h6);
      chk("rsz_rsp", log_q[3].data, 32'h6);
      chk("rsz_we", 32'(log_q[3].we), 32'd0);
    end else chk("rsrc_count", 32'(log_q.size()), 32'd4);

    // Back-pressure: three requests, rsp_ready low for 5 cycles
    log_q.delete();
    rsp_ready = 1'b0;
    fork
      begin
        send(2'd2, 5'd10, 2'b01, 12'h305, 32'h11, 1'b0, 1'b0);
        send(2'd2, 5'd11, 2'b10, 12'h305, 32'h22, 1'b0, 1'b0);
        send(2'd3, 5'd12, 2'b00, 12'h340, 32'h0, 1'b1, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        #1;
        chk("bp_accepts", 32'(exp_q.size()), 32'd2);
        chk("bp_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rsp_ready = 1'b1;
      end
    join
    drain();
    if (log_q.size() == 3) begin
      chk("bp_order0", 32'(log_q[0].rd), 32'd10);
      chk("bp_order1", 32'(log_q[1].rd), 32'd11);
      chk("bp_order2", 32'(log_q[2].rd), 32'd12);
      chk("bp_rs_old", log_q[1].data, 32'h11);
      chk("bp_rs_wdata", 32'(log_q[1].wdata), 32'h33);
    end else chk("bp_count", 32'(log_q.size()), 32'd3);

    // FP alias group: FRM write then FCSR read, same and different warp
    log_q.delete();
    send(2'd1, 5'd7, 2'b01, 12'h002, 32'h3, 1'b0, 1'b0);
    send(2'd1, 5'd8, 2'b00, 12'h003, 32'h0, 1'b1, 1'b0);
    drain();
    if (log_q.size() == 2) chk("alias_gap", 32'((log_q[1].t - log_q[0].t) / 10), 32'd2);
    else chk("alias_count", 32'(log_q.size()), 32'd2);
    log_q.delete();
    send(2'd1, 5'd7, 2'b01, 12'h002, 32'h5, 1'b0, 1'b0);
    send(2'd0, 5'd8, 2'b00, 12'h003, 32'h0, 1'b1, 1'b0);
    drain();
    if (log_q.size() == 2) chk("alias_wid_gap", 32'((log_q[1].t - log_q[0].t) / 10), 32'd1);
    else chk("alias_wid_count", 32'(log_q.size()), 32'd2);

    // Reset with X holding a write and rsp_ready low
    rsp_ready = 1'b0;
    send(2'd1, 5'd9, 2'b01, 12'h300, 32'h7F, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_write_en", 32'(write_enable), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    exp_q.delete();
    for (int w = 0; w < 4; w++)
      for (int a = 0; a < 4096; a++)
        spec_m[w][a] = commit_m[w][a];
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("dropped_write", 32'(mem[1][12'h300]), 32'h0);

    // Random traffic with random back-pressure
    for (int k = 0; k < 400; k++) begin
      src = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      send(2'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
           addrs[$urandom_range(0, 5)], src,
           (src == 32'd0) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          rsp_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
      end
    end
    rsp_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
